ula_issue_stage: RTL and testbench
==================================

// Module: ula_issue_stage
// PURPOSE
//  Decode/issue stage directly upstream of the ULA. Accepts 16-bit instructions (valid/ready),
//  reads a 4-entry register file and latches operands a/b plus ULAOp/dest into one output register.
//  Completed ULA results return on the write-back port; a busy scoreboard blocks RAW/WAW hazards.
// PARAMETERS
//  WIDTH     8   datapath width of registers, a, b, wb_data; must be >= 8
//  REG_INIT  0   reset value of every register-file entry
// PORTS
//  c          in   1      clock; all state changes on posedge c
//  rst_n      in   1      reset; asynchronous, active-low
//  in_valid   in   1      in_instr is valid
//  in_ready   out  1      stage accepts in_instr this cycle
//  in_instr   in   16     [15:14] op, [13] imm_sel, [12:11] rd, [10:9] rs1, [8:7] rs2, [6:0] imm
//  out_valid  out  1      a/b/ULAOp/out_dest hold a valid issued op
//  out_ready  in   1      ULA consumes the issued op this cycle
//  a          out  WIDTH  left operand = R[rs1]
//  b          out  WIDTH  right operand = imm_sel ? zero-extended imm : R[rs2]
//  ULAOp      out  2      op field, passed through unmodified
//  out_dest   out  2      rd of the issued op
//  wb_valid   in   1      write-back strobe
//  wb_dest    in   2      register to write
//  wb_data    in   WIDTH  ULA result
//  busy       out  4      scoreboard, bit i = R[i] has a result in flight
//  wb_unexp   out  1      1-cycle pulse: write-back hit a non-busy register
// BEHAVIOUR
//  Reset (async, rst_n=0): R[0..3]=REG_INIT, busy=0, out_valid=0, a=b=0, ULAOp=0, out_dest=0,
//   wb_unexp=0. A reset mid-operation drops the in-flight op and the pending result.
//  Write-back: on wb_valid, R[wb_dest]<=wb_data and busy[wb_dest]<=0 at the edge.
//   wb_unexp<=wb_valid & ~busy[wb_dest]; the write still occurs.
//  Effective busy: eb = busy & ~(wb_valid ? onehot(wb_dest) : 0).
//  Bypass: if wb_valid and wb_dest == a source register, the source reads wb_data, not R.
//  Hazard: eb[rs1] | (~imm_sel & eb[rs2]) | eb[rd].
//  Slot free: ~out_valid | out_ready. in_ready = slot_free & ~hazard (comb path from out_ready ok).
//  Accept (in_valid & in_ready) at edge N: a, b, ULAOp, out_dest loaded; out_valid=1 after edge N
//   (1-cycle latency); busy[rd]<=1. If rd==wb_dest in the same cycle, set wins over clear.
//  Output hold: out_valid & ~out_ready -> a/b/ULAOp/out_dest/out_valid unchanged.
//  Drain: out_ready & ~accept -> out_valid<=0; data outputs keep last values.
//  Back-to-back: out_ready=1 with a hazard-free stream sustains 1 issue/cycle.
//  in_instr is sampled only on accept; in_valid may drop without accept (no protocol error).
//  Width: imm zero-extended from 7 bits; no arithmetic performed in this block.
// STRUCTURE
//  Package nrisc_pkg: op constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_2=2'b10, OP_AND=2'b11);
//   instruction field msb/lsb localparams; NREGS=4.
//  Sub-module nrisc_regfile: 4xWIDTH, two async read ports with wb bypass, one sync write port,
//   async active-low reset. Scoreboard, hazard logic and output register stay in this module.
// TESTING
//  1 Reset: rst_n=0 mid-issue -> out_valid=0, busy=0, in_ready=1 immediately; R reads REG_INIT.
//  2 Imm issue: ADD rd=1 rs1=0 imm=7'h05, out_ready=1 -> next cycle a=0, b=8'h05, ULAOp=00,
//    out_dest=1, busy=4'b0010.
//  3 RAW: busy[1]=1, SUB rs1=1 -> in_ready=0; wb_valid dest=1 data=8'h2A in that cycle ->
//    accepted, a=8'h2A, busy[1]=0.
//  4 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0;
//    out_ready=1 -> next instr issued in the same edge.
//  5 Same-edge set/clear: wb dest=2 while accepting rd=2 (WAW cleared by bypass) -> busy[2]=1, R[2]=wb_data.
//  6 Unexpected wb: wb_valid dest=3 with busy[3]=0 -> wb_unexp pulse 1 cycle, R[3] updated.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared opcodes, instruction field positions and register-file geometry
// for the ULA issue stage.
package nrisc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_2   = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam int NREGS = 4;

  localparam int OP_MSB      = 15;
  localparam int OP_LSB      = 14;
  localparam int IMM_SEL_BIT = 13;
  localparam int RD_MSB      = 12;
  localparam int RD_LSB      = 11;
  localparam int RS1_MSB     = 10;
  localparam int RS1_LSB     = 9;
  localparam int RS2_MSB     = 8;
  localparam int RS2_LSB     = 7;
  localparam int IMM_MSB     = 6;
  localparam int IMM_LSB     = 0;

  function automatic logic [NREGS-1:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/nrisc_regfile.sv
// 4-entry register file: two combinational read ports that see a same-cycle
// write-back, one synchronous write port.
module nrisc_regfile
  import nrisc_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned REG_INIT = 0
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic [1:0]       i_ra1,
  input  logic [1:0]       i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  input  logic             i_we,
  input  logic [1:0]       i_wa,
  input  logic [WIDTH-1:0] i_wd
);

  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(REG_INIT);

  logic [WIDTH-1:0] r_mem [NREGS];

  // Register storage with write-back port
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= INIT_VAL;
      end
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_mem[i_ra1];
  assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_mem[i_ra2];

endmodule

// File: rtl/ula_issue_stage.sv
// Decode/issue stage feeding the ULA: register read with write-back bypass,
// busy scoreboard for RAW/WAW hazards, and a single registered issue slot.
module ula_issue_stage
  import nrisc_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned REG_INIT = 0
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [1:0]       ULAOp,
  output logic [1:0]       out_dest,
  input  logic             wb_valid,
  input  logic [1:0]       wb_dest,
  input  logic [WIDTH-1:0] wb_data,
  output logic [NREGS-1:0] busy,
  output logic             wb_unexp
);

  logic [1:0]       w_op;
  logic             w_imm_sel;
  logic [1:0]       w_rd;
  logic [1:0]       w_rs1;
  logic [1:0]       w_rs2;
  logic [6:0]       w_imm;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] w_b_sel;
  logic [NREGS-1:0] w_eb;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_hazard;
  logic             w_slot_free;
  logic             w_accept;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [1:0]       r_dest;
  logic [NREGS-1:0] r_busy;
  logic             r_wb_unexp;

  assign w_op      = in_instr[OP_MSB:OP_LSB];
  assign w_imm_sel = in_instr[IMM_SEL_BIT];
  assign w_rd      = in_instr[RD_MSB:RD_LSB];
  assign w_rs1     = in_instr[RS1_MSB:RS1_LSB];
  assign w_rs2     = in_instr[RS2_MSB:RS2_LSB];
  assign w_imm     = in_instr[IMM_MSB:IMM_LSB];

  nrisc_regfile #(
    .WIDTH    (WIDTH),
    .REG_INIT (REG_INIT)
  ) u_rf (
    .c     (c),
    .rst_n (rst_n),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (wb_valid),
    .i_wa  (wb_dest),
    .i_wd  (wb_data)
  );

  // A result arriving this cycle already resolves its register via the bypass
  assign w_eb        = r_busy & ~(wb_valid ? onehot(wb_dest) : 4'b0000);
  assign w_hazard    = w_eb[w_rs1] | (~w_imm_sel & w_eb[w_rs2]) | w_eb[w_rd];
  assign w_slot_free = ~r_out_valid | out_ready;
  assign in_ready    = w_slot_free & ~w_hazard;
  assign w_accept    = in_valid & in_ready;
  assign w_b_sel     = w_imm_sel ? {{(WIDTH-7){1'b0}}, w_imm} : w_rd2;

  // Scoreboard update: a new issue's set overrides a same-cycle write-back clear
  always_comb begin
    w_busy_nxt = w_eb;
    if (w_accept) begin
      w_busy_nxt = w_eb | onehot(w_rd);
    end else begin
      w_busy_nxt = w_eb;
    end
  end

  // Issue slot, scoreboard and unexpected write-back flag
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 2'b00;
      r_dest      <= 2'b00;
      r_busy      <= 4'b0000;
      r_wb_unexp  <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_wb_unexp <= wb_valid & ~r_busy[wb_dest];
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_a         <= w_rd1;
        r_b         <= w_b_sel;
        r_op        <= w_op;
        r_dest      <= w_rd;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign a         = r_a;
  assign b         = r_b;
  assign ULAOp     = r_op;
  assign out_dest  = r_dest;
  assign busy      = r_busy;
  assign wb_unexp  = r_wb_unexp;

endmodule

// File: tb/tb_ula_issue_stage.sv
// Directed bench for ula_issue_stage: a reference model predicts handshake,
// scoreboard and flags each cycle; issued ops are checked from a FIFO.
module tb_ula_issue_stage;
  import nrisc_pkg::*;

  localparam int W = 8;

  logic         c;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_instr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   ULAOp;
  logic [1:0]   out_dest;
  logic         wb_valid;
  logic [1:0]   wb_dest;
  logic [W-1:0] wb_data;
  logic [3:0]   busy;
  logic         wb_unexp;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [1:0]   dest;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] m_r [4];
  logic [3:0]   m_busy;
  logic         m_ov;
  logic         m_unexp;
  int           n_checks;
  int           n_errors;

  ula_issue_stage #(.WIDTH(W), .REG_INIT(0)) dut (
    .c         (c),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .ULAOp     (ULAOp),
    .out_dest  (out_dest),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .busy      (busy),
    .wb_unexp  (wb_unexp)
  );

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic isel,
                       input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [6:0] imm);
    in_valid = v;
    in_instr = {op, isel, rd, rs1, rs2, imm};
  endtask

  task automatic wb(input logic v, input logic [1:0] dest, input logic [W-1:0] data);
    wb_valid = v;
    wb_dest  = dest;
    wb_data  = data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_busy  = 4'b0000;
    m_ov    = 1'b0;
    m_unexp = 1'b0;
    sbq.delete();
  endtask

  // One clock: check comb handshake, retire/push ops, advance model, check state
  task automatic tick();
    logic [1:0] rd, rs1, rs2;
    logic       isel, h, er, acc;
    logic [3:0] eb;
    exp_t       e, g;
    #1;
    rd   = in_instr[12:11];
    rs1  = in_instr[10:9];
    rs2  = in_instr[8:7];
    isel = in_instr[13];
    eb   = m_busy;
    if (wb_valid) eb[wb_dest] = 1'b0;
    h  = eb[rs1] | (~isel & eb[rs2]) | eb[rd];
    er = (~m_ov | out_ready) & ~h;
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    chk("out_valid_pre", {31'd0, out_valid}, {31'd0, m_ov});
    if (m_ov && out_ready) begin
      n_checks++;
      assert (sbq.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_underflow: observed %0d entries expected >0", sbq.size());
      end
      if (sbq.size() > 0) begin
        g = sbq.pop_front();
        chk("issue_a", {24'd0, a}, {24'd0, g.a});
        chk("issue_b", {24'd0, b}, {24'd0, g.b});
        chk("issue_op", {30'd0, ULAOp}, {30'd0, g.op});
        chk("issue_dest", {30'd0, out_dest}, {30'd0, g.dest});
      end
    end
    acc = in_valid & er;
    if (acc) begin
      e.a    = (wb_valid && wb_dest == rs1) ? wb_data : m_r[rs1];
      e.b    = isel ? {1'b0, in_instr[6:0]} :
               ((wb_valid && wb_dest == rs2) ? wb_data : m_r[rs2]);
      e.op   = in_instr[15:14];
      e.dest = rd;
      sbq.push_back(e);
    end
    m_unexp = wb_valid & ~m_busy[wb_dest];
    if (wb_valid) begin
      m_r[wb_dest]    = wb_data;
      m_busy[wb_dest] = 1'b0;
    end
    if (acc) m_busy[rd] = 1'b1;
    if (acc) m_ov = 1'b1;
    else if (out_ready) m_ov = 1'b0;
    @(posedge c);
    #1;
    chk("busy", {28'd0, busy}, {28'd0, m_busy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("wb_unexp", {31'd0, wb_unexp}, {31'd0, m_unexp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0, 7'h00);
    wb(1'b0, 2'd0, 8'h00);
    model_reset();
    @(posedge c);
    @(posedge c);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {28'd0, busy}, 32'd0);
    chk("rst_a", {24'd0, a}, 32'd0);
    chk("rst_b", {24'd0, b}, 32'd0);
    chk("rst_wb_unexp", {31'd0, wb_unexp}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    // Immediate issue
    drive(1'b1, OP_ADD, 1'b1, 2'd1, 2'd0, 2'd0, 7'h05);
    tick();
    chk("imm_a", {24'd0, a}, 32'h00);
    chk("imm_b", {24'd0, b}, 32'h05);
    chk("imm_op", {30'd0, ULAOp}, 32'd0);
    chk("imm_dest", {30'd0, out_dest}, 32'd1);
    chk("imm_busy", {28'd0, busy}, 32'h2);

    // RAW on R1, resolved by same-cycle write-back bypass
    drive(1'b1, OP_SUB, 1'b0, 2'd2, 2'd1, 2'd0, 7'h00);
    tick();
    wb(1'b1, 2'd1, 8'h2A);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    chk("raw_a", {24'd0, a}, 32'h2A);
    chk("raw_op", {30'd0, ULAOp}, 32'd1);

    // Backpressure holds the slot, release issues the next op on the same edge
    out_ready = 1'b0;
    drive(1'b1, OP_AND, 1'b1, 2'd3, 2'd0, 2'd0, 7'h7F);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_a", {24'd0, a}, 32'h2A);
      chk("hold_dest", {30'd0, out_dest}, 32'd2);
    end
    out_ready = 1'b1;
    tick();
    chk("rel_op", {30'd0, ULAOp}, 32'd3);
    chk("rel_b", {24'd0, b}, 32'h7F);

    // WAW on R2 cleared by write-back in the same cycle: set wins
    drive(1'b1, OP_2, 1'b1, 2'd2, 2'd0, 2'd0, 7'h11);
    wb(1'b1, 2'd2, 8'hC3);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    chk("waw_busy2", {31'd0, busy[2]}, 32'd1);
    chk("waw_r2", {24'd0, dut.u_rf.r_mem[2]}, 32'hC3);

    // Expected write-back to R3, then an unexpected one
    drive(1'b0, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0, 7'h00);
    wb(1'b1, 2'd3, 8'h99);
    tick();
    wb(1'b1, 2'd3, 8'h3C);
    tick();
    chk("unexp_pulse", {31'd0, wb_unexp}, 32'd1);
    wb(1'b0, 2'd0, 8'h00);
    tick();
    chk("unexp_drop", {31'd0, wb_unexp}, 32'd0);

    // Back-to-back hazard-free stream reading R3
    drive(1'b1, OP_ADD, 1'b0, 2'd0, 2'd3, 2'd3, 7'h00);
    tick();
    drive(1'b1, OP_SUB, 1'b1, 2'd1, 2'd3, 2'd0, 7'h40);
    tick();
    drive(1'b1, OP_AND, 1'b0, 2'd3, 2'd3, 2'd3, 7'h00);
    tick();
    chk("b2b_a", {24'd0, a}, 32'h3C);

    // Reset while an op is held in the slot
    out_ready = 1'b0;
    drive(1'b1, OP_ADD, 1'b1, 2'd2, 2'd0, 2'd0, 7'h01);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {28'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_a", {24'd0, a}, 32'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_SUB, 1'b0, 2'd0, 2'd1, 2'd3, 7'h00);
    tick();
    chk("post_rst_a", {24'd0, a}, 32'h00);
    chk("post_rst_b", {24'd0, b}, 32'h00);
    drive(1'b0, OP_ADD, 1'b0, 2'd0, 2'd0, 2'd0, 7'h00);
    tick();
    chk("sb_empty", sbq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
